// File: rtl/imm_pkg.sv
// Shared constants for the immediate generator: select codes and default width.
package imm_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [3:0] SEL_I      = 4'd0;
  localparam logic [3:0] SEL_S      = 4'd1;
  localparam logic [3:0] SEL_B      = 4'd2;
  localparam logic [3:0] SEL_AUIPC  = 4'd3;
  localparam logic [3:0] SEL_J      = 4'd4;
  localparam logic [3:0] SEL_LUI    = 4'd5;
  localparam logic [3:0] SEL_ZIMM   = 4'd6;
  localparam logic [3:0] SEL_SHAMT5 = 4'd7;
  localparam logic [3:0] SEL_SHAMT6 = 4'd8;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: extracts and extends the immediate
// selected by imm_sel from instruction bits [31:7].
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [24:0]     instr,
  input  logic [3:0]      imm_sel,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [31:0] ir;
  logic [31:0] v32;

  // Every format fits in 32 bits; zero-extended formats leave bit 31 clear,
  // so a single sign extension from bit 31 covers all of them at any XLEN.
  always_comb begin
    ir      = {instr, 7'b0};
    v32     = '0;
    illegal = 1'b0;
    case (imm_sel)
      SEL_I:             v32 = {{20{ir[31]}}, ir[31:20]};
      SEL_S:             v32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      SEL_B:             v32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      SEL_AUIPC, SEL_LUI: v32 = {ir[31:12], 12'b0};
      SEL_J:             v32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      SEL_ZIMM:          v32 = {27'b0, ir[19:15]};
      SEL_SHAMT5:        v32 = {27'b0, ir[24:20]};
      SEL_SHAMT6: begin
        if (XLEN == 32) illegal = 1'b1;
        else            v32 = {26'b0, ir[25:20]};
      end
      default:           illegal = 1'b1;
    endcase
  end

  assign imm = XLEN'($signed(v32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode at the input, then a two-entry
// (output register + skid register) elastic buffer with an illegal counter.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [24:0]     instr,
  input  logic [3:0]      imm_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic            illegal,
  output logic [7:0]      err_cnt
);

  logic [XLEN-1:0] dec_imm;
  logic            dec_ill;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (instr),
    .imm_sel (imm_sel),
    .imm     (dec_imm),
    .illegal (dec_ill)
  );

  logic            skid_valid;
  logic [XLEN-1:0] skid_imm;
  logic            skid_ill;

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and in_ready is a pure register.
  logic in_fire, out_fire, drain, skid_load, skid_valid_nxt;

  always_comb begin
    in_fire        = in_valid & in_ready;
    out_fire       = out_valid & out_ready;
    drain          = out_fire | ~out_valid;
    skid_load      = in_fire & (skid_valid | ~drain);
    skid_valid_nxt = skid_load | (skid_valid & ~drain);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
      imm        <= '0;
      illegal    <= 1'b0;
      err_cnt    <= '0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_ill   <= 1'b0;
    end else begin
      // Output slot frees up: oldest entry (skid first) moves in.
      if (drain) begin
        if (skid_valid) begin
          out_valid <= 1'b1;
          imm       <= skid_imm;
          illegal   <= skid_ill;
        end else if (in_fire) begin
          out_valid <= 1'b1;
          imm       <= dec_imm;
          illegal   <= dec_ill;
        end else begin
          out_valid <= 1'b0;
        end
      end

      if (skid_load) begin
        skid_imm <= dec_imm;
        skid_ill <= dec_ill;
      end
      skid_valid <= skid_valid_nxt;
      in_ready   <= ~skid_valid_nxt;

      if (out_fire && illegal && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and
// are scored against an arithmetic reference model through one expected queue.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [24:0] instr = '0;
  logic [3:0]  imm_sel = '0;

  logic        in_ready32, out_valid32, illegal32;
  logic [31:0] imm32;
  logic [7:0]  err_cnt32;
  logic        in_ready64, out_valid64, illegal64;
  logic [63:0] imm64;
  logic [7:0]  err_cnt64;

  imm_gen_pipe #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .imm_sel(imm_sel), .out_valid(out_valid32),
    .out_ready(out_ready), .imm(imm32), .illegal(illegal32), .err_cnt(err_cnt32)
  );

  imm_gen_pipe #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .imm_sel(imm_sel), .out_valid(out_valid64),
    .out_ready(out_ready), .imm(imm64), .illegal(illegal64), .err_cnt(err_cnt64)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // reference model: {ill64, imm64[63:0], ill32, imm32[31:0]}
  localparam int EW = 98;
  logic [EW-1:0] exp_q[$];

  function automatic longint sx(input longint v, input int bits);
    if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
    return v;
  endfunction

  function automatic logic [EW-1:0] model(input logic [24:0] ins, input logic [3:0] sel);
    longint ir, v;
    bit ill32, ill64;
    logic [63:0] u64;
    logic [31:0] u32;
    ir = {32'd0, ins, 7'd0};
    v = 0;
    ill32 = 0;
    ill64 = 0;
    case (sel)
      4'd0: v = sx((ir >> 20) & 'hFFF, 12);
      4'd1: v = sx((((ir >> 25) & 'h7F) << 5) | ((ir >> 7) & 'h1F), 12);
      4'd2: v = sx((((ir >> 31) & 1) << 12) | (((ir >> 7) & 1) << 11) |
                   (((ir >> 25) & 'h3F) << 5) | (((ir >> 8) & 'hF) << 1), 13);
      4'd3, 4'd5: v = sx(ir & 'hFFFFF000, 32);
      4'd4: v = sx((((ir >> 31) & 1) << 20) | (ir & 'hFF000) |
                   (((ir >> 20) & 1) << 11) | (((ir >> 21) & 'h3FF) << 1), 21);
      4'd6: v = (ir >> 15) & 'h1F;
      4'd7: v = (ir >> 20) & 'h1F;
      4'd8: begin v = (ir >> 20) & 'h3F; ill32 = 1; end
      default: begin v = 0; ill32 = 1; ill64 = 1; end
    endcase
    u64 = v;
    u32 = ill32 ? 32'd0 : u64[31:0];
    if (ill64) u64 = '0;
    return {ill64, u64, ill32, u32};
  endfunction

  function automatic logic [24:0] hi(input logic [31:0] w);
    return w[31:7];
  endfunction

  // scoreboard / monitor, sampled on the falling edge
  int          err_m32 = 0;
  int          err_m64 = 0;
  bit          last_in_fire = 0;
  bit          prev_stall = 0;
  logic [31:0] hold32;
  logic [63:0] hold64;
  logic        hold_ill32, hold_ill64;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst) begin
      exp_q.delete();
      err_m32 = 0;
      err_m64 = 0;
      prev_stall = 0;
      last_in_fire = 0;
    end else begin
      check("err_cnt32", err_cnt32, err_m32);
      check("err_cnt64", err_cnt64, err_m64);
      check("out_valid32", out_valid32, exp_q.size() != 0);
      check("out_valid64", out_valid64, exp_q.size() != 0);
      check("in_ready32", in_ready32, exp_q.size() < 2);
      check("in_ready64", in_ready64, exp_q.size() < 2);
      if (prev_stall) begin
        check("hold_imm32", imm32, hold32);
        check("hold_imm64", imm64, hold64);
        check("hold_ill32", illegal32, hold_ill32);
        check("hold_ill64", illegal64, hold_ill64);
      end
      if (out_valid32 && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("imm64", imm64, e[96:33]);
          check("ill64", illegal64, e[97]);
          check("imm32", imm32, e[31:0]);
          check("ill32", illegal32, e[32]);
          if (e[32] && err_m32 < 255) err_m32++;
          if (e[97] && err_m64 < 255) err_m64++;
        end
      end
      last_in_fire = in_valid && in_ready32;
      if (last_in_fire) exp_q.push_back(model(instr, imm_sel));
      prev_stall = out_valid32 && !out_ready;
      hold32 = imm32;
      hold64 = imm64;
      hold_ill32 = illegal32;
      hold_ill64 = illegal64;
    end
  end

  // driver tasks; all are entered and left just after a rising edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [24:0] i, input logic [3:0] s);
    bit fired;
    fired = 0;
    in_valid = 1'b1;
    instr = i;
    imm_sel = s;
    for (int k = 0; k < 50 && !fired; k++) begin
      @(negedge clk);
      fired = in_ready32;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!fired) check("drive_timeout", 0, 1);
  endtask

  initial begin
    logic [24:0]   a, b, c, d;
    logic [EW-1:0] ea, eb, ec;
    int            start;

    rst = 1'b1;
    step(3);
    rst = 1'b0;
    check("rst_out_valid", out_valid32, 0);
    check("rst_in_ready", in_ready32, 1);
    check("rst_imm64", imm64, 0);
    check("rst_illegal", illegal32, 0);
    check("rst_err_cnt", err_cnt32, 0);

    // directed formats, one cycle after acceptance
    out_ready = 1'b1;
    drive(hi(32'hFFF00093), 4'd0);
    check("i_valid", out_valid32, 1);
    check("i_imm32", imm32, 32'hFFFFFFFF);
    check("i_ill", illegal32, 0);
    drive(hi(32'hFE000EE3), 4'd2);
    check("b_imm32", imm32, 32'hFFFFFFFC);
    check("b_imm64", imm64, 64'hFFFFFFFFFFFFFFFC);
    drive(hi(32'h800000B7), 4'd5);
    check("lui_imm64", imm64, 64'hFFFFFFFF80000000);
    check("lui_imm32", imm32, 32'h80000000);
    drive(hi(32'h000F8000), 4'd6);
    check("zimm_imm32", imm32, 32'h1F);
    drive(hi(32'h03F00013), 4'd8);
    check("shamt6_imm32", imm32, 0);
    check("shamt6_ill32", illegal32, 1);
    check("shamt6_imm64", imm64, 64'h3F);
    check("shamt6_ill64", illegal64, 0);
    step(1);
    check("shamt6_err32", err_cnt32, 1);
    check("shamt6_err64", err_cnt64, 0);

    // backpressure: A held, B in skid, C stalled, then in-order drain
    out_ready = 1'b0;
    a = 25'($urandom); b = 25'($urandom); c = 25'($urandom);
    ea = model(a, 4'd0); eb = model(b, 4'd4); ec = model(c, 4'd1);
    drive(a, 4'd0);
    drive(b, 4'd4);
    check("bp_in_ready", in_ready32, 0);
    in_valid = 1'b1; instr = c; imm_sel = 4'd1;
    step(3);
    check("bp_stall_ready", in_ready32, 0);
    check("bp_hold_a", imm32, ea[31:0]);
    out_ready = 1'b1;
    step(1);
    check("bp_out_b", imm64, eb[96:33]);
    step(1);
    in_valid = 1'b0;
    check("bp_out_c", imm64, ec[96:33]);
    check("bp_c_valid", out_valid32, 1);
    step(1);
    check("bp_empty", out_valid32, 0);

    // reset with both entries full
    out_ready = 1'b0;
    d = 25'($urandom);
    drive(d, 4'd3);
    drive(~d, 4'd7);
    check("full_in_ready", in_ready32, 0);
    rst = 1'b1;
    step(1);
    check("rst2_out_valid", out_valid32, 0);
    check("rst2_in_ready", in_ready32, 1);
    check("rst2_err_cnt", err_cnt32, 0);
    check("rst2_imm64", imm64, 0);
    check("rst2_illegal", illegal64, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    step(5);
    check("rst2_no_stale", out_valid32, 0);

    // 300 illegal transfers back to back: full throughput, counter saturates
    start = cyc;
    for (int i = 0; i < 300; i++) drive(25'($urandom), 4'($urandom_range(9, 15)));
    check("throughput", cyc - start, 300);
    step(2);
    check("sat_err32", err_cnt32, 255);
    check("sat_err64", err_cnt64, 255);
    for (int i = 0; i < 10; i++) drive(25'($urandom), 4'd15);
    step(2);
    check("sat_hold32", err_cnt32, 255);

    // random traffic with random backpressure
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!in_valid || last_in_fire) begin
        in_valid = ($urandom_range(0, 3) != 0);
        instr = 25'($urandom);
        imm_sel = 4'($urandom_range(0, 15));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step(4);
    check("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 The block SHALL have one parameter: XLEN, default 32, immediate output width; legal values are 32 and 64.
REQ-002 Port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 Port rst  input  1  reset, synchronous and active-high.
REQ-004 Port in_valid  input  1  upstream instruction valid.
REQ-005 Port in_ready  output  1  block can accept an instruction.
REQ-006 Port instr  input  25  instruction bits [31:7].
REQ-007 Port imm_sel  input  4  immediate format select, per REQ-010.
REQ-008 Port out_valid / out_ready  output / input  1 / 1  downstream handshake.
REQ-009 Ports imm (output, XLEN, extended immediate), illegal (output, 1, unsupported select), err_cnt (output, 8, saturating illegal count).

Function
REQ-010 imm_sel encoding SHALL be:
- 0: I, sign-extended instr[31:20].
- 1: S, sign-extended {instr[31:25], instr[11:7]}.
- 2: B, sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- 3: AUIPC and 5: LUI, {instr[31:12], 12'b0} sign-extended from bit 31.
- 4: J, sign-extended {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- 6: CSR zimm, zero-extended instr[19:15].
- 7: 5-bit shamt, zero-extended instr[24:20].
- 8: 6-bit shamt, zero-extended instr[25:20].
REQ-011 All sign extension SHALL replicate instr[31] up to bit XLEN-1.
REQ-012 Select 8 with XLEN=32, and selects 9-15, SHALL produce imm=0 with illegal=1; otherwise illegal=0. X SHALL never be driven.
REQ-013 A transfer SHALL occur on each rising edge where valid and ready are both high; the input side and the output side are independent.
REQ-014 Latency SHALL be 1 cycle: an instruction accepted at edge N, with an empty buffer, presents out_valid=1 after edge N.
REQ-015 Storage SHALL be an output register plus one skid register (2 entries total), in FIFO order.
REQ-016 in_ready SHALL be 1 exactly when the skid register is empty; it SHALL be a register output with no combinational path from out_ready.
REQ-017 While out_valid=1 and out_ready=0, imm and illegal SHALL hold stable.
REQ-018 Simultaneous accept and drain with an empty skid register SHALL load the output register directly; with a full skid register, the skid entry SHALL move to the output register and the new input SHALL take the skid slot.
REQ-019 Throughput SHALL be 1 instruction per cycle while out_ready=1.
REQ-020 err_cnt SHALL increment by 1 when an illegal result transfers out (output-side handshake), and SHALL saturate at 255.
REQ-021 When out_valid=0, imm and illegal SHALL hold their last value; they are don't-care to consumers.

Reset
REQ-022 Reset SHALL set out_valid=0, in_ready=1, imm=0, illegal=0, err_cnt=0 and empty both entries on the edge where rst=1.
REQ-023 Reset asserted mid-operation SHALL discard all buffered instructions; no transfer SHALL occur on that edge.

Structure
REQ-024 Package imm_pkg SHALL hold the imm_sel code constants (REQ-010) and the XLEN default.
REQ-025 The format decode SHALL be a combinational sub-module imm_decode (parameter XLEN; ports instr, imm_sel, imm, illegal), instantiated once at the input side.
REQ-026 The skid/output control SHALL live in imm_gen_pipe with no further sub-modules.

Verification
REQ-027 I-type with instr=0xFFF00093[31:7], sel 0, XLEN=32 -> imm=0xFFFFFFFF, illegal=0, 1 cycle after acceptance.
REQ-028 B-type with 0xFE000EE3[31:7], sel 2 -> imm=0xFFFFFFFC; LUI with 0x800000B7[31:7], sel 5, XLEN=64 -> imm=0xFFFFFFFF80000000.
REQ-029 CSR zimm with instr[19:15]=0x1F, sel 6 -> imm=0x1F; sel 8 at XLEN=32 -> imm=0, illegal=1, err_cnt +1.
REQ-030 Backpressure: three back-to-back inputs A, B, C with out_ready=0 -> A held on output, B in skid, in_ready=0, C stalled; then out_ready=1 -> A, B, C delivered in order on consecutive cycles, none lost or duplicated.
REQ-031 300 illegal transfers -> err_cnt=255 and holds.
REQ-032 rst pulsed with both entries full -> next cycle out_valid=0, in_ready=1, err_cnt=0, and no buffered data ever appears on the output.
